// File: rtl/seq_mag_comp.sv
// Multi-cycle unsigned magnitude comparator: walks A/B MSB-first two bits per
// cycle through an external 2-bit slice and stops at the first unequal pair.
module seq_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       slice_x,
  output logic [1:0]       slice_y,
  input  logic             slice_gt,
  input  logic             slice_lt,
  input  logic             slice_eq,
  output logic             busy,
  output logic             done,
  output logic             agtb,
  output logic             altb,
  output logic             aeqb
);

  localparam int NP    = WIDTH / 2;
  localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;
  localparam int NSLOT = 2 ** IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             agtb_q, agtb_d, altb_q, altb_d, aeqb_q, aeqb_d;

  // The slice's eq output is redundant with !gt && !lt; kept on the port only.
  logic unused_slice_eq;
  assign unused_slice_eq = slice_eq;

  // Pair lookup tables padded to a power of two so idx can never select
  // past the end, even for the single-pair case.
  logic [1:0] a_pair [NSLOT];
  logic [1:0] b_pair [NSLOT];

  for (genvar i = 0; i < NSLOT; i++) begin : g_pair
    if (i < NP) begin : g_real
      assign a_pair[i] = a_q[2*i +: 2];
      assign b_pair[i] = b_q[2*i +: 2];
    end else begin : g_pad
      assign a_pair[i] = 2'b00;
      assign b_pair[i] = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
      aeqb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
      aeqb_q  <= aeqb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
    aeqb_d  = aeqb_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(NP - 1);
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          aeqb_d  = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        // gt wins over lt; neither asserted means this pair is equal.
        if (slice_gt) begin
          agtb_d  = 1'b1;
          state_d = S_DONE;
        end else if (slice_lt) begin
          altb_d  = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          aeqb_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    slice_x = 2'b00;
    slice_y = 2'b00;
    unique case (state_q)
      S_CMP: begin
        busy    = 1'b1;
        slice_x = a_pair[idx_q];
        slice_y = b_pair[idx_q];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign agtb = agtb_q;
  assign altb = altb_q;
  assign aeqb = aeqb_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: an 8-bit instance and a 2-bit instance, each with a
// behavioural 2-bit slice; results and latency come from plain arithmetic.
module tb_seq_mag_comp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] sx8, sy8;
  logic       gt8, lt8, eq8;
  logic       busy8, done8, agtb8, altb8, aeqb8;

  assign gt8 = (sx8 > sy8);
  assign lt8 = (sx8 < sy8);
  assign eq8 = (sx8 == sy8);

  seq_mag_comp #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .slice_x(sx8), .slice_y(sy8),
    .slice_gt(gt8), .slice_lt(lt8), .slice_eq(eq8),
    .busy(busy8), .done(done8), .agtb(agtb8), .altb(altb8), .aeqb(aeqb8)
  );

  // 2-bit instance, slice stub can force gt and lt together
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic [1:0] sx2, sy2;
  logic       gt2, lt2, eq2;
  logic       busy2, done2, agtb2, altb2, aeqb2;
  logic       force_both = 1'b0;

  assign gt2 = force_both | (sx2 > sy2);
  assign lt2 = force_both | (sx2 < sy2);
  assign eq2 = !force_both && (sx2 == sy2);

  seq_mag_comp #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .slice_x(sx2), .slice_y(sy2),
    .slice_gt(gt2), .slice_lt(lt2), .slice_eq(eq2),
    .busy(busy2), .done(done2), .agtb(agtb2), .altb(altb2), .aeqb(aeqb2)
  );

  function automatic logic [1:0] pair8(input logic [7:0] v, input int p);
    logic [7:0] t;
    t = v >> (2 * p);
    return t[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({busy8, done8, agtb8, altb8, aeqb8, sx8, sy8} !== 9'b0) begin
      n_err++;
      $display("FAIL reset8: got %b want 000000000", {busy8, done8, agtb8, altb8, aeqb8, sx8, sy8});
    end
    n_cmp++;
    if ({busy2, done2, agtb2, altb2, aeqb2, sx2, sy2} !== 9'b0) begin
      n_err++;
      $display("FAIL reset2: got %b want 000000000", {busy2, done2, agtb2, altb2, aeqb2, sx2, sy2});
    end
    rst = 1'b0;
    tick();
  endtask

  // One full compare on the 8-bit instance; optionally hammers start with new
  // operands while busy/done to confirm they are ignored.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit interfere);
    int k;
    logic [2:0] exp_flags;
    k = 4;
    for (int p = 0; p < 4; p++) begin
      if (pair8(ta, 3 - p) != pair8(tb, 3 - p)) begin
        k = p + 1;
        break;
      end
    end
    exp_flags = {ta > tb, ta < tb, ta == tb};

    a8 = ta; b8 = tb; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    if (interfere) begin
      a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    end
    for (int j = 0; j < k; j++) begin
      n_cmp++;
      if ({busy8, done8, agtb8, altb8, aeqb8, sx8, sy8} !==
          {2'b10, 3'b000, pair8(ta, 3 - j), pair8(tb, 3 - j)}) begin
        n_err++;
        $display("FAIL cmp8 a=%h b=%h step %0d: got %b want %b", ta, tb, j,
                 {busy8, done8, agtb8, altb8, aeqb8, sx8, sy8},
                 {2'b10, 3'b000, pair8(ta, 3 - j), pair8(tb, 3 - j)});
      end
      tick();
    end
    n_cmp++;
    if ({busy8, done8, agtb8, altb8, aeqb8, sx8, sy8} !== {2'b01, exp_flags, 4'b0000}) begin
      n_err++;
      $display("FAIL done8 a=%h b=%h: got %b want %b", ta, tb,
               {busy8, done8, agtb8, altb8, aeqb8, sx8, sy8}, {2'b01, exp_flags, 4'b0000});
    end
    tick();
    start8 = 1'b0;
    n_cmp++;
    if ({busy8, done8, agtb8, altb8, aeqb8, sx8, sy8} !== {2'b00, exp_flags, 4'b0000}) begin
      n_err++;
      $display("FAIL hold8 a=%h b=%h: got %b want %b", ta, tb,
               {busy8, done8, agtb8, altb8, aeqb8, sx8, sy8}, {2'b00, exp_flags, 4'b0000});
    end
  endtask

  task automatic run2(input logic [1:0] ta, input logic [1:0] tb, input bit both);
    logic [2:0] exp_flags;
    exp_flags = both ? 3'b100 : {ta > tb, ta < tb, ta == tb};
    force_both = both;
    a2 = ta; b2 = tb; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n_cmp++;
    if ({busy2, done2, agtb2, altb2, aeqb2, sx2, sy2} !== {5'b10000, ta, tb}) begin
      n_err++;
      $display("FAIL cmp2 a=%b b=%b: got %b want %b", ta, tb,
               {busy2, done2, agtb2, altb2, aeqb2, sx2, sy2}, {5'b10000, ta, tb});
    end
    tick();
    n_cmp++;
    if ({busy2, done2, agtb2, altb2, aeqb2, sx2, sy2} !== {2'b01, exp_flags, 4'b0000}) begin
      n_err++;
      $display("FAIL done2 a=%b b=%b: got %b want %b", ta, tb,
               {busy2, done2, agtb2, altb2, aeqb2, sx2, sy2}, {2'b01, exp_flags, 4'b0000});
    end
    tick();
    force_both = 1'b0;
    n_cmp++;
    if ({busy2, done2, agtb2, altb2, aeqb2} !== {2'b00, exp_flags}) begin
      n_err++;
      $display("FAIL hold2 a=%b b=%b: got %b want %b", ta, tb,
               {busy2, done2, agtb2, altb2, aeqb2}, {2'b00, exp_flags});
    end
  endtask

  task automatic test_directed();
    run8(8'hA5, 8'hA5, 1'b0);
    run8(8'hC0, 8'h40, 1'b0);
    run8(8'h12, 8'h13, 1'b0);
  endtask

  task automatic test_back_to_back();
    run8(8'h12, 8'h13, 1'b1);
    run8(8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_rst_idle();
    run8(8'h80, 8'h7F, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy8, done8, agtb8, altb8, aeqb8} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_idle: got %b want 00000", {busy8, done8, agtb8, altb8, aeqb8});
    end
  endtask

  task automatic test_abort();
    int pulses;
    a8 = 8'hA5; b8 = 8'hA5; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy8, done8, agtb8, altb8, aeqb8, sx8, sy8} !== 9'b0) begin
      n_err++;
      $display("FAIL abort: got %b want 000000000", {busy8, done8, agtb8, altb8, aeqb8, sx8, sy8});
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done8 || busy8) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d busy/done cycles want 0", pulses);
    end
    run8(8'h01, 8'h02, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] ta, tb, mask;
    int m;
    for (int i = 0; i < 40; i++) begin
      ta   = 8'($urandom);
      m    = $urandom_range(0, 4);
      mask = 8'hFF >> (2 * m);
      tb   = ta ^ (8'($urandom) & mask);
      run8(ta, tb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_width2();
    run2(2'b10, 2'b10, 1'b0);
    run2(2'b01, 2'b10, 1'b1);
    run2(2'b01, 2'b11, 1'b0);
    run2(2'b11, 2'b00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_rst_idle();
    test_abort();
    test_width2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
